// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm sequencing controller: state encoding and widths.
package alarm_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_SIREN       = 3'd4
  } state_t;

endpackage

// File: rtl/alarm_delay_counter.sv
// Down-counter shared by the exit, entry and siren delays; holds at zero instead of wrapping.
module alarm_delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // A load always beats a decrement so a state change starts its delay cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_controller.sv
// Sequencing FSM around the combinational alarm block: exit/entry delays, panic and siren timeout.
// Optional door chime is built when ALARM_CHIME_EN is defined.
module alarm_controller
  import alarm_ctrl_pkg::*;
#(
  parameter int EXIT_CYCLES  = 16,
  parameter int ENTRY_CYCLES = 8,
  parameter int SIREN_CYCLES = 32,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               disarm,
  input  logic               panic,
  input  logic               window,
  input  logic               door,
  input  logic               garage,
  input  logic               trip,
  output logic               enable,
  output logic               exiting,
  output logic               siren,
  output logic               armed_led,
  output logic               arm_fault,
  output logic               chime,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_CYCLES - 1);

  state_t           state_q, nxt;
  logic             panic_src, nxt_psrc;
  logic             ld, dec, zero, fault;
  logic [CNT_W-1:0] ld_val;
  logic             all_closed;

  assign all_closed = window & door & garage;

  alarm_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .zero     (zero)
  );

  // Next-state and counter control; panic overrides everything, then disarm, then timers/trip, then arm.
  always_comb begin
    nxt      = state_q;
    nxt_psrc = panic_src;
    ld       = 1'b0;
    ld_val   = '0;
    dec      = 1'b0;
    fault    = 1'b0;
    if (panic) begin
      nxt    = ST_SIREN;
      ld     = 1'b1;
      ld_val = SIREN_LD;
      if (state_q == ST_DISARMED) nxt_psrc = 1'b1;
      else if (state_q != ST_SIREN) nxt_psrc = 1'b0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm && !disarm) begin
            if (all_closed) begin
              nxt    = ST_EXIT_DELAY;
              ld     = 1'b1;
              ld_val = EXIT_LD;
            end else begin
              fault = 1'b1;
            end
          end
        end
        ST_EXIT_DELAY: begin
          if (disarm)    nxt = ST_DISARMED;
          else if (zero) nxt = ST_ARMED;
          else           dec = 1'b1;
        end
        ST_ARMED: begin
          if (disarm) begin
            nxt = ST_DISARMED;
          end else if (trip) begin
            nxt    = ST_ENTRY_DELAY;
            ld     = 1'b1;
            ld_val = ENTRY_LD;
          end
        end
        ST_ENTRY_DELAY: begin
          if (disarm) begin
            nxt = ST_DISARMED;
          end else if (zero) begin
            nxt      = ST_SIREN;
            nxt_psrc = 1'b0;
            ld       = 1'b1;
            ld_val   = SIREN_LD;
          end else begin
            dec = 1'b1;
          end
        end
        ST_SIREN: begin
          if (disarm)    nxt = ST_DISARMED;
          else if (zero) nxt = panic_src ? ST_DISARMED : ST_ARMED;
          else           dec = 1'b1;
        end
        default: nxt = ST_DISARMED;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_DISARMED;
      panic_src <= 1'b0;
      enable    <= 1'b0;
      exiting   <= 1'b0;
      siren     <= 1'b0;
      armed_led <= 1'b0;
      arm_fault <= 1'b0;
    end else begin
      state_q   <= nxt;
      panic_src <= nxt_psrc;
      enable    <= (nxt != ST_DISARMED);
      exiting   <= (nxt == ST_EXIT_DELAY);
      siren     <= (nxt == ST_SIREN);
      armed_led <= (nxt == ST_ARMED) || (nxt == ST_ENTRY_DELAY);
      arm_fault <= fault;
    end
  end

  assign state = state_q;

`ifdef ALARM_CHIME_EN
  logic [2:0] sens_q;
  logic       chime_q;

  // Sensors are captured during reset so an already-open sensor does not chime on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      sens_q  <= {window, door, garage};
      chime_q <= 1'b0;
    end else begin
      sens_q  <= {window, door, garage};
      chime_q <= (state_q == ST_DISARMED) && (|(sens_q & ~{window, door, garage}));
    end
  end

  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller; chime expectations follow ALARM_CHIME_EN.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset, arm, disarm, panic, window, door, garage, trip;
  logic       enable, exiting, siren, armed_led, arm_fault, chime;
  logic [2:0] state;
  logic [7:0] obs;
  int         checks = 0;
  int         errors = 0;

  // obs = {enable, exiting, siren, armed_led, arm_fault, state}
  localparam logic [7:0] EXP_DIS   = 8'b00000_000;
  localparam logic [7:0] EXP_FAULT = 8'b00001_000;
  localparam logic [7:0] EXP_EXIT  = 8'b11000_001;
  localparam logic [7:0] EXP_ARMED = 8'b10010_010;
  localparam logic [7:0] EXP_ENTRY = 8'b10010_011;
  localparam logic [7:0] EXP_SIREN = 8'b10100_100;

`ifdef ALARM_CHIME_EN
  localparam logic EXP_CHIME = 1'b1;
`else
  localparam logic EXP_CHIME = 1'b0;
`endif

  always #5 clk = ~clk;

  assign obs = {enable, exiting, siren, armed_led, arm_fault, state};

  alarm_controller dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .disarm    (disarm),
    .panic     (panic),
    .window    (window),
    .door      (door),
    .garage    (garage),
    .trip      (trip),
    .enable    (enable),
    .exiting   (exiting),
    .siren     (siren),
    .armed_led (armed_led),
    .arm_fault (arm_fault),
    .chime     (chime),
    .state     (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_armed();
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (16) tick();
  endtask

  task automatic do_disarm(input string name);
    disarm = 1'b1; tick(); disarm = 1'b0;
    checks++; if (obs !== EXP_DIS) begin errors++; $display("[TB] FAIL %s: got %b expected %b", name, obs, EXP_DIS); end
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 0; disarm = 0; panic = 0; trip = 0;
    window = 1; door = 1; garage = 1;
    repeat (2) tick();
    checks++; if (obs !== EXP_DIS) begin errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", obs, EXP_DIS); end
    checks++; if (chime !== 1'b0) begin errors++; $display("[TB] FAIL reset_chime: got %b expected 0", chime); end
    reset = 1'b0;
    tick();
    checks++; if (obs !== EXP_DIS) begin errors++; $display("[TB] FAIL idle_after_reset: got %b expected %b", obs, EXP_DIS); end
  endtask

  task automatic test_arm_exit();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (obs !== EXP_EXIT) begin errors++; $display("[TB] FAIL exit_delay[%0d]: got %b expected %b", i, obs, EXP_EXIT); end
      tick();
    end
    checks++; if (obs !== EXP_ARMED) begin errors++; $display("[TB] FAIL armed_after_exit: got %b expected %b", obs, EXP_ARMED); end
    tick();
    checks++; if (obs !== EXP_ARMED) begin errors++; $display("[TB] FAIL armed_hold: got %b expected %b", obs, EXP_ARMED); end
    do_disarm("disarm_from_armed");
  endtask

  task automatic test_arm_fault();
    door = 1'b0; arm = 1'b1; tick(); arm = 1'b0;
    checks++; if (obs !== EXP_FAULT) begin errors++; $display("[TB] FAIL arm_fault_pulse: got %b expected %b", obs, EXP_FAULT); end
    tick();
    checks++; if (obs !== EXP_DIS) begin errors++; $display("[TB] FAIL arm_fault_clear: got %b expected %b", obs, EXP_DIS); end
    door = 1'b1;
    arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
    checks++; if (obs !== EXP_DIS) begin errors++; $display("[TB] FAIL arm_and_disarm: got %b expected %b", obs, EXP_DIS); end
  endtask

  task automatic test_entry_siren();
    go_armed();
    trip = 1'b1; tick(); trip = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (obs !== EXP_ENTRY) begin errors++; $display("[TB] FAIL entry_delay[%0d]: got %b expected %b", i, obs, EXP_ENTRY); end
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      checks++; if (obs !== EXP_SIREN) begin errors++; $display("[TB] FAIL trip_siren[%0d]: got %b expected %b", i, obs, EXP_SIREN); end
      tick();
    end
    checks++; if (obs !== EXP_ARMED) begin errors++; $display("[TB] FAIL siren_rearm: got %b expected %b", obs, EXP_ARMED); end
    do_disarm("disarm_after_rearm");
  endtask

  task automatic test_entry_disarm();
    go_armed();
    trip = 1'b1; tick(); trip = 1'b0;
    tick(); tick();
    checks++; if (obs !== EXP_ENTRY) begin errors++; $display("[TB] FAIL entry_before_disarm: got %b expected %b", obs, EXP_ENTRY); end
    do_disarm("entry_disarm");
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (siren !== 1'b0) begin errors++; $display("[TB] FAIL no_siren[%0d]: got %b expected 0", i, siren); end
    end
  endtask

  task automatic test_panic();
    panic = 1'b1; disarm = 1'b1; tick(); panic = 1'b0; disarm = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++; if (obs !== EXP_SIREN) begin errors++; $display("[TB] FAIL panic_siren[%0d]: got %b expected %b", i, obs, EXP_SIREN); end
      tick();
    end
    checks++; if (obs !== EXP_DIS) begin errors++; $display("[TB] FAIL panic_timeout_disarmed: got %b expected %b", obs, EXP_DIS); end
    go_armed();
    panic = 1'b1; tick(); panic = 1'b0;
    for (int i = 0; i < 32; i++) tick();
    checks++; if (obs !== EXP_ARMED) begin errors++; $display("[TB] FAIL armed_panic_timeout: got %b expected %b", obs, EXP_ARMED); end
    do_disarm("disarm_after_armed_panic");
  endtask

  task automatic test_panic_hold();
    panic = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++; if (obs !== EXP_SIREN) begin errors++; $display("[TB] FAIL panic_hold[%0d]: got %b expected %b", i, obs, EXP_SIREN); end
    end
    panic = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    checks++; if (obs !== EXP_SIREN) begin errors++; $display("[TB] FAIL panic_release_last: got %b expected %b", obs, EXP_SIREN); end
    tick();
    checks++; if (obs !== EXP_DIS) begin errors++; $display("[TB] FAIL panic_release_done: got %b expected %b", obs, EXP_DIS); end
  endtask

  task automatic test_rearm_open();
    go_armed();
    trip = 1'b1;
    for (int i = 0; i < 41; i++) tick();
    checks++; if (obs !== EXP_ARMED) begin errors++; $display("[TB] FAIL rearm_open_armed: got %b expected %b", obs, EXP_ARMED); end
    tick();
    checks++; if (obs !== EXP_ENTRY) begin errors++; $display("[TB] FAIL rearm_open_entry: got %b expected %b", obs, EXP_ENTRY); end
    trip = 1'b0;
    do_disarm("disarm_after_reentry");
  endtask

  task automatic test_reset_mid_siren();
    panic = 1'b1; tick(); panic = 1'b0;
    repeat (5) tick();
    checks++; if (obs !== EXP_SIREN) begin errors++; $display("[TB] FAIL siren_before_reset: got %b expected %b", obs, EXP_SIREN); end
    reset = 1'b1; tick();
    checks++; if (obs !== EXP_DIS) begin errors++; $display("[TB] FAIL reset_mid_siren: got %b expected %b", obs, EXP_DIS); end
    reset = 1'b0; tick();
    checks++; if (obs !== EXP_DIS) begin errors++; $display("[TB] FAIL after_reset_release: got %b expected %b", obs, EXP_DIS); end
  endtask

  task automatic test_chime();
    window = 1'b0; tick();
    checks++; if (chime !== EXP_CHIME) begin errors++; $display("[TB] FAIL chime_pulse: got %b expected %b", chime, EXP_CHIME); end
    tick();
    checks++; if (chime !== 1'b0) begin errors++; $display("[TB] FAIL chime_single: got %b expected 0", chime); end
    window = 1'b1; tick();
    checks++; if (chime !== 1'b0) begin errors++; $display("[TB] FAIL chime_on_close: got %b expected 0", chime); end
  endtask

  initial begin
    test_reset();
    test_arm_exit();
    test_arm_fault();
    test_entry_siren();
    test_entry_disarm();
    test_panic();
    test_panic_hold();
    test_rearm_open();
    test_reset_mid_siren();
    test_chime();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
